// File: rtl/fifo_wr_arbiter_if.sv
// Write-port bundle between the requesters, the arbiter and the downstream FIFO.
// master = requester/FIFO side, slave = arbiter.
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     fifo_full;
  logic                     fifo_wr_en;
  logic [WIDTH-1:0]         fifo_data;
  logic                     grant_valid;
  logic [ID_W-1:0]          grant_id;

  modport master (
    output req_valid, req_data, fifo_full,
    input  req_ready, fifo_wr_en, fifo_data, grant_valid, grant_id
  );

  modport slave (
    input  req_valid, req_data, fifo_full,
    output req_ready, fifo_wr_en, fifo_data, grant_valid, grant_id
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter: one requester owns the FIFO write port for up to
// MAX_BURST beats, then ownership rotates starting after the last owner.
module fifo_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input logic              clk,
  input logic              rst_n,
  fifo_wr_arbiter_if.slave bus
);
  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t                         state_q;
  logic [ID_W-1:0]                grant_id_q, last_id_q;
  logic [CNT_W-1:0]               beat_cnt_q;

  logic [NUM_REQ-1:0]             rdy;
  logic [NUM_REQ-1:0][WIDTH-1:0]  data_lanes;
  logic                           beat, last_beat, rel;
  logic                           win_vld;
  logic [ID_W-1:0]                win_id, idx;

  assign data_lanes = bus.req_data;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
    assign rdy[g] = (state_q == GRANT) && (grant_id_q == ID_W'(g)) && !bus.fifo_full;
  end

  assign beat      = bus.req_valid[grant_id_q] && rdy[grant_id_q];
  assign last_beat = beat && (beat_cnt_q == CNT_W'(MAX_BURST - 1));
  // A stalled owner (fifo_full) keeps its grant; only burst end or dropped valid release it.
  assign rel       = (state_q == GRANT) && (last_beat || !bus.req_valid[grant_id_q]);

  // Scan last_id+1 .. last_id (wrapping) so the previous owner is tried last.
  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    idx     = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = ID_W'((int'(last_id_q) + k) % NUM_REQ);
      if (!win_vld && bus.req_valid[idx]) begin
        win_vld = 1'b1;
        win_id  = idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      grant_id_q <= '0;
      beat_cnt_q <= '0;
      last_id_q  <= ID_W'(NUM_REQ - 1);
    end else if (state_q == IDLE || rel) begin
      beat_cnt_q <= '0;
      if (win_vld) begin
        state_q    <= GRANT;
        grant_id_q <= win_id;
        last_id_q  <= win_id;
      end else begin
        state_q    <= IDLE;
        grant_id_q <= '0;
      end
    end else if (beat) begin
      beat_cnt_q <= beat_cnt_q + CNT_W'(1);
    end
  end

  assign bus.req_ready   = rdy;
  assign bus.fifo_wr_en  = beat;
  assign bus.fifo_data   = beat ? data_lanes[grant_id_q] : '0;
  assign bus.grant_valid = (state_q == GRANT);
  assign bus.grant_id    = grant_id_q;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter (NUM_REQ=4, WIDTH=8, MAX_BURST=4).
module tb_fifo_wr_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  int   n_chk = 0;
  int   n_err = 0;
  int   n_wr;

  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.NUM_REQ(4), .WIDTH(8)) bus ();

  fifo_wr_arbiter #(.NUM_REQ(4), .WIDTH(8), .MAX_BURST(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h exp %0h", tag, obs, exp);
    end
  endtask

  // Check one cycle against expectations, then advance to the next negedge.
  task automatic cyc(input string tag, input bit gv, input int id, input bit we);
    logic [3:0] rdy_e;
    logic [7:0] dat_e;
    #1;
    rdy_e = (gv && !bus.fifo_full) ? 4'(1 << id) : 4'd0;
    dat_e = we ? 8'(8'h11 * (id + 1)) : 8'h00;
    chk({tag, ".gv"},  32'(bus.grant_valid), 32'(gv));
    chk({tag, ".id"},  32'(bus.grant_id),    32'(gv ? id : 0));
    chk({tag, ".we"},  32'(bus.fifo_wr_en),  32'(we));
    chk({tag, ".rdy"}, 32'(bus.req_ready),   32'(rdy_e));
    chk({tag, ".dat"}, 32'(bus.fifo_data),   32'(dat_e));
    if (bus.fifo_wr_en) n_wr++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    bus.req_valid = '0;
    bus.fifo_full = 1'b0;
    @(negedge clk);
    bus.req_valid = 4'b1111;
    #1;
    chk("rst.rdy", 32'(bus.req_ready),   32'd0);
    chk("rst.we",  32'(bus.fifo_wr_en),  32'd0);
    chk("rst.dat", 32'(bus.fifo_data),   32'd0);
    chk("rst.gv",  32'(bus.grant_valid), 32'd0);
    chk("rst.id",  32'(bus.grant_id),    32'd0);
    @(negedge clk);
    bus.req_valid = '0;
    rst_n         = 1'b1;
    n_wr          = 0;
  endtask

  initial begin
    bus.req_data  = {8'h44, 8'h33, 8'h22, 8'h11};
    bus.req_valid = '0;
    bus.fifo_full = 1'b0;
    rst_n         = 1'b0;
    @(negedge clk);

    // Requesters 1 and 3: burst of 1, then 3 with no bubble, then 1 again
    do_reset();
    bus.req_valid = 4'b1010;
    cyc("t1.idle", 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc("t1.r1", 1, 1, 1);
    for (int i = 0; i < 4; i++) cyc("t1.r3", 1, 3, 1);
    cyc("t1.r1b", 1, 1, 1);
    chk("t1.nwr", 32'(n_wr), 32'd9);

    // All valid: order 0,1,2,3,0
    do_reset();
    bus.req_valid = 4'b1111;
    cyc("t2.idle", 0, 0, 0);
    for (int g = 0; g < 4; g++)
      for (int i = 0; i < 4; i++) cyc("t2.rr", 1, g, 1);
    chk("t2.nwr", 32'(n_wr), 32'd16);
    cyc("t2.wrap", 1, 0, 1);

    // Full stall mid-burst of requester 2
    do_reset();
    bus.req_valid = 4'b0100;
    cyc("t3.idle", 0, 0, 0);
    cyc("t3.b1", 1, 2, 1);
    cyc("t3.b2", 1, 2, 1);
    bus.fifo_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1 chk("t3.cnt", 32'(dut.beat_cnt_q), 32'd2);
      cyc("t3.full", 1, 2, 0);
    end
    bus.fifo_full = 1'b0;
    cyc("t3.b3", 1, 2, 1);
    #1 chk("t3.cnt3", 32'(dut.beat_cnt_q), 32'd3);
    cyc("t3.b4", 1, 2, 1);
    #1 chk("t3.cnt0", 32'(dut.beat_cnt_q), 32'd0);
    bus.req_valid = 4'b0000;
    cyc("t3.drop", 1, 2, 0);
    cyc("t3.idle2", 0, 0, 0);
    chk("t3.nwr", 32'(n_wr), 32'd4);

    // Owner 0 drops valid after one beat; requester 1 takes over
    do_reset();
    bus.req_valid = 4'b0011;
    cyc("t4.idle", 0, 0, 0);
    cyc("t4.b1", 1, 0, 1);
    bus.req_valid = 4'b0010;
    cyc("t4.drop", 1, 0, 0);
    #1 chk("t4.cnt", 32'(dut.beat_cnt_q), 32'd0);
    cyc("t4.r1", 1, 1, 1);

    // Only requester 3: back-to-back re-grants
    do_reset();
    bus.req_valid = 4'b1000;
    cyc("t5.idle", 0, 0, 0);
    for (int i = 0; i < 9; i++) cyc("t5.r3", 1, 3, 1);
    chk("t5.nwr", 32'(n_wr), 32'd9);

    // Reset mid-burst of requester 1
    do_reset();
    bus.req_valid = 4'b0010;
    cyc("t6.idle", 0, 0, 0);
    cyc("t6.b1", 1, 1, 1);
    #1 chk("t6.pre", 32'(bus.fifo_wr_en), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t6.rdy", 32'(bus.req_ready),   32'd0);
    chk("t6.we",  32'(bus.fifo_wr_en),  32'd0);
    chk("t6.dat", 32'(bus.fifo_data),   32'd0);
    chk("t6.gv",  32'(bus.grant_valid), 32'd0);
    chk("t6.id",  32'(bus.grant_id),    32'd0);
    bus.req_valid = 4'b0011;
    @(negedge clk);
    rst_n = 1'b1;
    cyc("t6.idle2", 0, 0, 0);
    cyc("t6.r0", 1, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of write requesters (range 2..16).
REQ-002 SHALL have parameter WIDTH, default 8, data width of each requester and of the FIFO write port.
REQ-003 SHALL have parameter MAX_BURST, default 4, maximum beats accepted per grant (range 1..255).
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port req_valid  input  NUM_REQ  per-requester write-request valid.
REQ-007 SHALL have port req_data  input  NUM_REQ*WIDTH  requester i data in bits [i*WIDTH +: WIDTH].
REQ-008 SHALL have port req_ready  output  NUM_REQ  per-requester accept; at most one bit set.
REQ-009 SHALL have port fifo_full  input  1  full flag from the downstream FIFO.
REQ-010 SHALL have port fifo_wr_en  output  1  FIFO write enable.
REQ-011 SHALL have port fifo_data  output  WIDTH  FIFO write data.
REQ-012 SHALL have port grant_valid  output  1  high while a requester owns the FIFO (state GRANT).
REQ-013 SHALL have port grant_id  output  clog2(NUM_REQ)  index of current owner; 0 when grant_valid=0.

Function
REQ-014 SHALL implement a two-state FSM: IDLE (no owner) and GRANT (owner = grant_id).
REQ-015 SHALL hold registers state, grant_id, beat_cnt (clog2(MAX_BURST+1) bits) and last_id (previous owner).
REQ-016 SHALL drive req_ready[i] = (state==GRANT) && (grant_id==i) && !fifo_full, combinationally; all other bits 0.
REQ-017 SHALL define beat accepted = req_valid[grant_id] && req_ready[grant_id]; fifo_wr_en = beat accepted, zero cycles latency.
REQ-018 SHALL drive fifo_data = req_data slice of grant_id when fifo_wr_en=1, and all zeros otherwise.
REQ-019 SHALL increment beat_cnt by 1 on each accepted beat; beat_cnt never exceeds MAX_BURST.
REQ-020 SHALL release the grant at an edge when state is GRANT and either (a) an accepted beat brings beat_cnt to MAX_BURST, or (b) req_valid[grant_id]=0.
REQ-021 SHALL NOT release the grant because of fifo_full; while fifo_full=1, owner, beat_cnt and state hold.
REQ-022 SHALL arbitrate at every edge where state is IDLE or a release occurs: winner = first set bit of req_valid scanning indices last_id+1, last_id+2, ... mod NUM_REQ, ending at last_id itself.
REQ-023 SHALL, when arbitration finds a winner, enter GRANT with grant_id=winner, beat_cnt=0, last_id=winner, at that same edge (no idle bubble between grants).
REQ-024 SHALL, when arbitration finds no valid requester, enter IDLE; last_id retains its value.
REQ-025 SHALL, in IDLE, keep req_ready=0 and fifo_wr_en=0; first beat from a new owner can be accepted one cycle after its req_valid is sampled.
REQ-026 SHALL allow the previous owner to be re-granted immediately after burst expiry only when no other requester is valid.
REQ-027 SHALL require requesters to hold req_data stable while req_valid=1 and not accepted; the arbiter does not buffer data.

Reset
REQ-028 SHALL, on rst_n low, asynchronously set state=IDLE, grant_id=0, beat_cnt=0, last_id=NUM_REQ-1 (requester 0 highest priority after reset).
REQ-029 SHALL, during reset, drive req_ready=0, fifo_wr_en=0, fifo_data=0, grant_valid=0, grant_id=0.
REQ-030 SHALL, on reset asserted mid-burst, drop the grant immediately with no partial-state carry-over; beats accepted before reset remain in the FIFO.

Verification
REQ-031 SHALL pass: after reset, req_valid=4'b1010, fifo_full=0 -> requester 1 granted next edge; its 4 beats written on consecutive cycles; then requester 3 granted with no bubble.
REQ-032 SHALL pass: all four requesters continuously valid, MAX_BURST=4 -> grant order 0,1,2,3,0; exactly 4 fifo_wr_en pulses per grant, 16 writes in 16 accept cycles plus one initial arbitration cycle.
REQ-033 SHALL pass: requester 2 owns grant, fifo_full=1 for 5 cycles after beat 2 -> req_ready=0, fifo_wr_en=0, grant_id=2, beat_cnt=2 held; beats 3 and 4 complete after full clears.
REQ-034 SHALL pass: owner 0 drops req_valid after 1 beat while requester 1 valid -> release at next edge, grant_id=1, beat_cnt=0.
REQ-035 SHALL pass: only requester 3 valid continuously -> re-granted every MAX_BURST beats with no gap in fifo_wr_en.
REQ-036 SHALL pass: rst_n pulsed low mid-burst of requester 1 -> all outputs zero within the same cycle; after release with req_valid=4'b0011, requester 0 granted first.
